dpram_burst_reader: RTL and testbench
=====================================

Name: dpram_burst_reader

Overview:
- Read-side engine for the dual-port RAM: drives the RAM read port (port enable 1, address 1) and turns a burst request into a valid/ready output stream.
- Pairs with a writer on port 0. Converts the RAM's fixed 1-cycle registered read latency into a backpressure-safe stream, using a small internal buffer.
- Sits between the RAM and any downstream consumer, e.g. a UART TX or checksum unit.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 4, RAM address width.
- DEPTH, 16, RAM words; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  burst request; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first RAM address of the burst.
- length  input  ADDR_WIDTH+1  number of words to read, 0..2*DEPTH-1.
- ram_en  output  1  RAM read-port enable (port_en_1).
- ram_addr  output  ADDR_WIDTH  RAM read address (addr_in_1).
- ram_rdata  input  DATA_WIDTH  RAM read data (data_out_1); valid 1 cycle after ram_en is sampled.
- m_data  output  DATA_WIDTH  stream data.
- m_valid  output  1  stream data valid.
- m_ready  input  1  consumer ready.
- m_last  output  1  high with the final beat of the burst.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the final beat handshake.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE; FIFO is flushed; in-flight flag is cleared.
  - ram_en, ram_addr, m_data, m_valid, m_last, busy and done all drive 0.
  - Reset mid-burst abandons the burst with no done pulse.
- States:
  - IDLE: start=1 with length>0 latches base_addr and length and moves to READ. start=1 with length=0 moves to FIN.
  - READ: issues reads. Moves to DRAIN when the issued count equals length.
  - DRAIN: waits for the final beat handshake (m_valid & m_ready & m_last), then moves to FIN.
  - FIN: done=1 for exactly one cycle, then IDLE.
- busy = (state != IDLE).
- start outside IDLE is ignored. start in the cycle after FIN (IDLE) is accepted normally.
- Issue rule:
  - ram_en = (state==READ) & (issued<length) & (fifo_count + inflight < 3).
  - This is combinational from registered state only; there is no path from m_ready.
  - ram_addr is a registered counter: loaded with base_addr on accept, incremented modulo DEPTH on each ram_en cycle. FFF..F wraps to 0.
  - length > DEPTH re-reads wrapped addresses; this is legal.
- Read return:
  - inflight is set on the clock edge where ram_en=1, and cleared the next cycle.
  - While inflight=1, ram_rdata is pushed into a 3-entry FIFO at that cycle's edge.
  - The FIFO never overflows, by the issue rule.
- Output:
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - m_data and m_last hold stable while m_valid & !m_ready.
  - Pop on m_valid & m_ready. Push and pop in the same cycle are both honoured.
  - m_last marks beat number length (tracked by a per-beat tag or a beat counter).
- Latency and throughput:
  - Start sampled at edge E0. ram_en is high in cycle 1, ram_rdata is valid in cycle 2, first m_valid is in cycle 3.
  - With m_ready held high, throughput is 1 word/cycle.
  - done rises the cycle after the final handshake and state returns to IDLE one cycle later.

Test Plan:
- Full burst: preload RAM addr i-1 = i for i=1..16; start, base 0, length 16, m_ready=1 -> ram_en high cycles 1..16; m_data 1..16 on consecutive cycles starting cycle 3; m_last only on 16; done one cycle after beat 16; busy low afterwards.
- Backpressure: same burst with m_ready toggling 1,0,0,1 pattern -> every word 1..16 delivered exactly once in order; m_data stable while stalled; FIFO count never exceeds 3; ram_en drops when fifo_count+inflight=3.
- Wrap: base 14, length 4 -> ram_addr 14,15,0,1; m_data 15,16,1,2; m_last on 2.
- Zero length: start with length 0 -> no ram_en, no m_valid; busy high 1 cycle, done pulse, back to IDLE.
- Start while busy: second start (base 5) during burst base 0 length 8 -> ignored, output is 1..8 only. Start in the IDLE cycle after done -> accepted.
- Reset mid-burst: assert rst_n=0 after beat 3 of a 16-word burst -> all outputs 0 immediately, no done. New burst base 8, length 2 after release -> 9,10.

Source files
------------

// File: rtl/dpram_burst_reader.sv
// Read-side burst engine for the dual-port RAM: issues port-1 reads and turns the
// fixed 1-cycle registered read latency into a backpressure-safe valid/ready stream.
module dpram_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int LW         = ADDR_WIDTH + 1;
    localparam int FIFO_DEPTH = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         issued_q, issued_d;
    logic [LW-1:0]         beat_q, beat_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic [2:0]            occupancy;
    logic                  hs;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Issue gating counts the in-flight read as occupied so the 3-entry FIFO cannot overflow.
    always_comb begin
        occupancy = {1'b0, count_q} + {2'b0, inflight_q};
        ram_en    = (state_q == S_READ) && (issued_q < len_q) && (occupancy < 3'(FIFO_DEPTH));
        ram_addr  = addr_q;
        m_valid   = (count_q != 2'd0);
        m_data    = m_valid ? mem_q[rd_ptr_q] : '0;
        m_last    = m_valid && (beat_q == len_q - LW'(1));
        hs        = m_valid && m_ready;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_FIN);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        beat_d     = beat_q;
        inflight_d = ram_en;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + {1'b0, inflight_q} - {1'b0, hs};

        if (inflight_q) begin
            mem_d[wr_ptr_q] = ram_rdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (hs) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            beat_d   = beat_q + LW'(1);
        end
        if (ram_en) begin
            issued_d = issued_q + LW'(1);
            addr_d   = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    len_d    = length;
                    issued_d = '0;
                    beat_d   = '0;
                    state_d  = (length != '0) ? S_READ : S_FIN;
                end
            end
            S_READ: begin
                if (issued_q == len_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (hs && m_last) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            beat_q     <= beat_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Self-checking bench for dpram_burst_reader: behavioural port-1 RAM plus a queue
// scoreboard of expected beats filled when each burst is requested.
module tb_dpram_burst_reader;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] exp_data_q [$];
    logic          exp_last_q [$];
    int            vectors = 0;
    int            miscompares = 0;

    dpram_burst_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .ram_en   (ram_en),
        .ram_addr (ram_addr),
        .ram_rdata(ram_rdata),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // RAM read port with its fixed one-cycle registered latency
    always_ff @(posedge clk) begin
        if (ram_en) ram_rdata <= ram[ram_addr];
    end

    // Queues expected beats and holds start across exactly one rising edge (E0).
    task automatic kick(input int b, input int len);
        for (int i = 0; i < len; i++) begin
            exp_data_q.push_back(DW'(((b + i) % DEPTH) + 1));
            exp_last_q.push_back(i == len - 1);
        end
        start = 1'b1;
        base_addr = AW'(b);
        length = (AW + 1)'(len);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({ram_en, ram_addr, m_data, m_valid, m_last, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got en=%b addr=%0d data=%0d v=%b l=%b busy=%b done=%b, want all 0",
                     ram_en, ram_addr, m_data, m_valid, m_last, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b m_valid=%b, want 0 0", busy, m_valid);
        end
    endtask

    task automatic test_full_burst();
        logic [DW-1:0] ed;
        logic          el;
        m_ready = 1'b1;
        @(negedge clk);
        kick(0, 16);
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (ram_en !== (c <= 16)) begin
                miscompares++;
                $display("FAIL full_ram_en c=%0d: got %b want %b", c, ram_en, c <= 16);
            end
            if (ram_en && ram_addr !== AW'(c - 1)) begin
                miscompares++;
                $display("FAIL full_ram_addr c=%0d: got %0d want %0d", c, ram_addr, c - 1);
            end
            vectors++;
            if (m_valid !== (c >= 3 && c <= 18)) begin
                miscompares++;
                $display("FAIL full_m_valid c=%0d: got %b want %b", c, m_valid, c >= 3 && c <= 18);
            end
            vectors++;
            if (done !== (c == 19) || busy !== (c <= 19)) begin
                miscompares++;
                $display("FAIL full_done_busy c=%0d: got done=%b busy=%b want %b %b",
                         c, done, busy, c == 19, c <= 19);
            end
            if (m_valid && m_ready && exp_data_q.size() > 0) begin
                ed = exp_data_q.pop_front();
                el = exp_last_q.pop_front();
                vectors++;
                if (m_data !== ed || m_last !== el) begin
                    miscompares++;
                    $display("FAIL full_beat c=%0d: got data=%0d last=%b want %0d %b", c, m_data, m_last, ed, el);
                end
            end
        end
        vectors++;
        if (exp_data_q.size() != 0) begin
            miscompares++;
            $display("FAIL full_leftover: got %0d undelivered beats, want 0", exp_data_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] ed;
        logic          el;
        logic [DW-1:0] held = '0;
        logic          held_last = 1'b0;
        bit            prev_stall = 1'b0;
        bit            saw_done = 1'b0;
        bit            exp_en;
        bit            pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int            cnt = 0;
        int            infl = 0;
        int            issued = 0;
        @(negedge clk);
        kick(0, 16);
        for (int c = 1; c <= 120 && !saw_done; c++) begin
            @(negedge clk);
            m_ready = pat[(c - 1) % 4];
            #1;
            exp_en = (issued < 16) && (cnt + infl < 3);
            vectors++;
            if (ram_en !== exp_en || m_valid !== (cnt != 0)) begin
                miscompares++;
                $display("FAIL bp_flow c=%0d: got en=%b valid=%b want %b %b (cnt=%0d infl=%0d)",
                         c, ram_en, m_valid, exp_en, cnt != 0, cnt, infl);
            end
            if (prev_stall) begin
                vectors++;
                if (m_data !== held || m_last !== held_last) begin
                    miscompares++;
                    $display("FAIL bp_stable c=%0d: got %0d/%b want %0d/%b", c, m_data, m_last, held, held_last);
                end
            end
            if (m_valid && m_ready) begin
                if (exp_data_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL bp_extra c=%0d: got data=%0d want no beat", c, m_data);
                end else begin
                    ed = exp_data_q.pop_front();
                    el = exp_last_q.pop_front();
                    vectors++;
                    if (m_data !== ed || m_last !== el) begin
                        miscompares++;
                        $display("FAIL bp_beat c=%0d: got %0d/%b want %0d/%b", c, m_data, m_last, ed, el);
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            held = m_data;
            held_last = m_last;
            cnt = cnt + infl - ((m_valid && m_ready) ? 1 : 0);
            infl = ram_en ? 1 : 0;
            issued += ram_en ? 1 : 0;
            saw_done = done;
        end
        vectors++;
        if (!saw_done || exp_data_q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_complete: got done=%b leftover=%0d, want 1 0", saw_done, exp_data_q.size());
        end
        m_ready = 1'b1;
    endtask

    task automatic test_wrap();
        logic [DW-1:0] ed;
        logic          el;
        logic [AW-1:0] exp_addr [$] = '{4'd14, 4'd15, 4'd0, 4'd1};
        logic [AW-1:0] ea;
        bit            saw_done = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        kick(14, 4);
        for (int c = 1; c <= 20 && !saw_done; c++) begin
            @(negedge clk);
            #1;
            if (ram_en) begin
                ea = (exp_addr.size() > 0) ? exp_addr.pop_front() : 'x;
                vectors++;
                if (ram_addr !== ea) begin
                    miscompares++;
                    $display("FAIL wrap_addr c=%0d: got %0d want %0d", c, ram_addr, ea);
                end
            end
            if (m_valid && m_ready && exp_data_q.size() > 0) begin
                ed = exp_data_q.pop_front();
                el = exp_last_q.pop_front();
                vectors++;
                if (m_data !== ed || m_last !== el) begin
                    miscompares++;
                    $display("FAIL wrap_beat c=%0d: got %0d/%b want %0d/%b", c, m_data, m_last, ed, el);
                end
            end
            saw_done = done;
        end
        vectors++;
        if (!saw_done || exp_data_q.size() != 0 || exp_addr.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_complete: got done=%b beats_left=%0d addrs_left=%0d, want 1 0 0",
                     saw_done, exp_data_q.size(), exp_addr.size());
        end
    endtask

    task automatic test_zero_length();
        @(negedge clk);
        kick(3, 0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (ram_en !== 1'b0 || m_valid !== 1'b0 || busy !== (c == 1) || done !== (c == 1)) begin
                miscompares++;
                $display("FAIL zero_len c=%0d: got en=%b v=%b busy=%b done=%b want 0 0 %b %b",
                         c, ram_en, m_valid, busy, done, c == 1, c == 1);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [DW-1:0] ed;
        logic          el;
        bit            saw_done = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        kick(0, 8);
        for (int c = 1; c <= 30 && !saw_done; c++) begin
            @(negedge clk);
            if (c == 4) begin
                start = 1'b1;
                base_addr = AW'(5);
                length = (AW + 1)'(3);
            end else begin
                start = 1'b0;
            end
            #1;
            if (m_valid && m_ready) begin
                ed = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : 'x;
                el = (exp_last_q.size() > 0) ? exp_last_q.pop_front() : 1'bx;
                vectors++;
                if (m_data !== ed || m_last !== el) begin
                    miscompares++;
                    $display("FAIL busy_beat c=%0d: got %0d/%b want %0d/%b", c, m_data, m_last, ed, el);
                end
            end
            saw_done = done;
        end
        start = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (!saw_done || busy !== 1'b0 || exp_data_q.size() != 0) begin
            miscompares++;
            $display("FAIL busy_end: got done=%b busy=%b leftover=%0d want 1 0 0", saw_done, busy, exp_data_q.size());
        end
        kick(10, 2);
        saw_done = 1'b0;
        for (int c = 1; c <= 20 && !saw_done; c++) begin
            @(negedge clk);
            #1;
            if (c == 1) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL idle_accept: got busy=%b want 1", busy);
                end
            end
            if (m_valid && m_ready && exp_data_q.size() > 0) begin
                ed = exp_data_q.pop_front();
                el = exp_last_q.pop_front();
                vectors++;
                if (m_data !== ed || m_last !== el) begin
                    miscompares++;
                    $display("FAIL idle_beat c=%0d: got %0d/%b want %0d/%b", c, m_data, m_last, ed, el);
                end
            end
            saw_done = done;
        end
        vectors++;
        if (!saw_done || exp_data_q.size() != 0) begin
            miscompares++;
            $display("FAIL idle_complete: got done=%b leftover=%0d want 1 0", saw_done, exp_data_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [DW-1:0] ed;
        logic          el;
        int            beats = 0;
        bit            saw_done = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        kick(0, 16);
        for (int c = 1; c <= 20 && beats < 3; c++) begin
            @(negedge clk);
            #1;
            if (m_valid && m_ready) begin
                beats++;
                ed = exp_data_q.pop_front();
                el = exp_last_q.pop_front();
                vectors++;
                if (m_data !== ed || m_last !== el) begin
                    miscompares++;
                    $display("FAIL rst_pre_beat c=%0d: got %0d/%b want %0d/%b", c, m_data, m_last, ed, el);
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({ram_en, ram_addr, m_data, m_valid, m_last, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got en=%b addr=%0d data=%0d v=%b l=%b busy=%b done=%b want all 0",
                     ram_en, ram_addr, m_data, m_valid, m_last, busy, done);
        end
        exp_data_q.delete();
        exp_last_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_no_done c=%0d: got done=%b busy=%b v=%b want 0 0 0", c, done, busy, m_valid);
            end
        end
        kick(8, 2);
        for (int c = 1; c <= 20 && !saw_done; c++) begin
            @(negedge clk);
            #1;
            if (m_valid && m_ready && exp_data_q.size() > 0) begin
                ed = exp_data_q.pop_front();
                el = exp_last_q.pop_front();
                vectors++;
                if (m_data !== ed || m_last !== el) begin
                    miscompares++;
                    $display("FAIL rst_post_beat c=%0d: got %0d/%b want %0d/%b", c, m_data, m_last, ed, el);
                end
            end
            saw_done = done;
        end
        vectors++;
        if (!saw_done || exp_data_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_post_complete: got done=%b leftover=%0d want 1 0", saw_done, exp_data_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i + 1);
        repeat (2) @(negedge clk);
        #1;
        test_reset();
        test_full_burst();
        test_backpressure();
        test_wrap();
        test_zero_length();
        test_start_while_busy();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units, want finish");
        $fatal(1);
    end

endmodule
